// File: rtl/hwag_math_pkg.sv
// Shared types and helpers for the HWAG math library blocks.
package hwag_math_pkg;

  // Divider sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

  // Width of a counter that must hold the values 0..width.
  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract division step.
module div_step #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] rem_in,
  input  logic             bit_in,
  input  logic [Width-1:0] divisor,
  output logic [Width-1:0] rem_out,
  output logic             q_bit
);

  logic [Width-1:0] minuend;
  logic [Width:0]   diff;

  // Shift the next dividend bit in, trial-subtract, restore on borrow.
  always_comb begin
    minuend = {rem_in[Width-2:0], bit_in};
    diff    = {1'b0, minuend} - {1'b0, divisor};
    q_bit   = ~diff[Width];
    rem_out = q_bit ? diff[Width-1:0] : minuend;
  end

endmodule

// File: rtl/integer_division_sequencer.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// Optional zero-divisor shortcut and flag: define HWAG_DIV_ZERO_CHECK_EN.
module integer_division_sequencer
  import hwag_math_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = div_cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shift register, MSB consumed first
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;   // quotient shift register
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(
    .Width (WIDTH)
  ) u_div_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

`ifdef HWAG_DIV_ZERO_CHECK_EN
  logic div_zero_q, div_zero_d;
`endif

  // Next-state and datapath update for the accept/step/done sequence.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef HWAG_DIV_ZERO_CHECK_EN
    div_zero_d  = div_zero_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StRun;
`ifdef HWAG_DIV_ZERO_CHECK_EN
          // Zero divisor: skip the steps and report the restoring result directly.
          if (divisor == '0) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
          end
`endif
        end
      end
      StRun: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quotient_d  = {quo_q[WIDTH-2:0], step_q};
          remainder_d = step_rem;
`ifdef HWAG_DIV_ZERO_CHECK_EN
          div_zero_d  = 1'b0;
`endif
          state_d     = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

`ifdef HWAG_DIV_ZERO_CHECK_EN
  // Zero-divisor flag, refreshed with every result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_zero_q <= 1'b0;
    end else begin
      div_zero_q <= div_zero_d;
    end
  end
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_integer_division_sequencer.sv
// Directed bench for integer_division_sequencer at WIDTH=8 and WIDTH=16.
module tb_integer_division_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  dividend8 = '0, divisor8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  q8, r8;

  logic        start16 = 1'b0;
  logic [15:0] dividend16 = '0, divisor16 = '0;
  logic        busy16, done16, dz16;
  logic [15:0] q16, r16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  integer_division_sequencer #(
    .WIDTH (8)
  ) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .dividend  (dividend8),
    .divisor   (divisor8),
    .busy      (busy8),
    .done      (done8),
    .quotient  (q8),
    .remainder (r8),
    .div_zero  (dz8)
  );

  integer_division_sequencer #(
    .WIDTH (16)
  ) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start16),
    .dividend  (dividend16),
    .divisor   (divisor16),
    .busy      (busy16),
    .done      (done16),
    .quotient  (q16),
    .remainder (r16),
    .div_zero  (dz16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check("done8_seen", {31'd0, done8}, 32'd1);
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    while (!done16 && n < 40) begin
      tick();
      n++;
    end
    check("done16_seen", {31'd0, done16}, 32'd1);
  endtask

  initial begin
    int n;
    int busy_cnt;
    int pulses;
    logic exp_dz;
    int   exp_zero_cycles;

    // Reset state
    #1;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_quot", {24'd0, q8}, 32'd0);
    check("rst_rem", {24'd0, r8}, 32'd0);
    check("rst_dz", {31'd0, dz8}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // 100 / 7 = 14 r 2, busy for exactly 8 cycles
    start8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
    tick();
    start8 = 1'b0;
    check("acc_quot_hold", {24'd0, q8}, 32'd0);
    busy_cnt = 0;
    while (busy8 && busy_cnt < 40) begin
      busy_cnt++;
      tick();
    end
    check("busy_cycles", busy_cnt, 8);
    check("d100_done", {31'd0, done8}, 32'd1);
    check("d100_quot", {24'd0, q8}, 32'd14);
    check("d100_rem", {24'd0, r8}, 32'd2);
    tick();
    check("done_pulse_one", {31'd0, done8}, 32'd0);

    // 255 / 1 then 5 / 9 back-to-back, second start during DONE
    start8 = 1'b1; dividend8 = 8'd255; divisor8 = 8'd1;
    tick();
    start8 = 1'b0;
    wait_done8(n);
    check("d255_cycles", n, 8);
    check("d255_quot", {24'd0, q8}, 32'd255);
    check("d255_rem", {24'd0, r8}, 32'd0);
    start8 = 1'b1; dividend8 = 8'd5; divisor8 = 8'd9;
    tick();
    start8 = 1'b0;
    check("b2b_busy", {31'd0, busy8}, 32'd1);
    check("b2b_quot_hold", {24'd0, q8}, 32'd255);
    wait_done8(n);
    check("b2b_gap", n + 1, 9);
    check("d5_quot", {24'd0, q8}, 32'd0);
    check("d5_rem", {24'd0, r8}, 32'd5);
    tick();

    // WIDTH=16: 0xFFFF / 0x00FF, with a start of 10/3 during RUN ignored
    start16 = 1'b1; dividend16 = 16'hFFFF; divisor16 = 16'h00FF;
    tick();
    start16 = 1'b0; dividend16 = '0; divisor16 = '0;
    tick();
    tick();
    tick();
    start16 = 1'b1; dividend16 = 16'd10; divisor16 = 16'd3;
    tick();
    start16 = 1'b0; dividend16 = '0; divisor16 = '0;
    wait_done16(n);
    check("w16_cycles", n + 4, 16);
    check("w16_quot", {16'd0, q16}, 32'h0101);
    check("w16_rem", {16'd0, r16}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done16) pulses++;
    end
    check("w16_no_extra_done", pulses, 0);
    check("w16_idle", {31'd0, busy16}, 32'd0);
    check("w16_quot_hold", {16'd0, q16}, 32'h0101);

    // Zero divisor, dividend 0x5A
`ifdef HWAG_DIV_ZERO_CHECK_EN
    exp_dz = 1'b1;
    exp_zero_cycles = 0;
`else
    exp_dz = 1'b0;
    exp_zero_cycles = 8;
`endif
    start8 = 1'b1; dividend8 = 8'h5A; divisor8 = 8'h00;
    tick();
    start8 = 1'b0;
    wait_done8(n);
    check("dz_cycles", n, exp_zero_cycles);
    check("dz_quot", {24'd0, q8}, 32'hFF);
    check("dz_rem", {24'd0, r8}, 32'h5A);
    check("dz_flag", {31'd0, dz8}, {31'd0, exp_dz});
    tick();

    // Reset at step 4 of 200 / 3 aborts, then a fresh 200 / 3
    start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd3;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    check("abort_quot", {24'd0, q8}, 32'd0);
    check("abort_rem", {24'd0, r8}, 32'd0);
    check("abort_dz", {31'd0, dz8}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8 || busy8) pulses++;
    end
    check("abort_no_done", pulses, 0);
    rst = 1'b1;
    tick();
    start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd3;
    tick();
    start8 = 1'b0;
    wait_done8(n);
    check("d200_cycles", n, 8);
    check("d200_quot", {24'd0, q8}, 32'd66);
    check("d200_rem", {24'd0, r8}, 32'd2);
    check("d200_dz", {31'd0, dz8}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/integer_division_sequencer.md
# integer_division_sequencer

Multi-cycle unsigned integer divider for the HWAG math library. It accepts a dividend and a divisor through a start/busy/done handshake and runs one restoring shift-subtract step per clock, MSB of the dividend first. It returns a registered quotient and remainder. Angle/period scaling logic uses it wherever a non-constant divisor rules out a combinational divide.

## Interface
- WIDTH, 16: operand, quotient and remainder width in bits; legal range 2..32.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the block is not busy.
- dividend  in  WIDTH  numerator; captured on the accepting edge.
- divisor  in  WIDTH  denominator; captured on the accepting edge.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div_zero  out  1  divisor was zero for the last result. Only meaningful with the configuration macro; otherwise tied 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge:
  - capture dividend into the shift register and divisor into the divisor register;
  - clear the partial remainder;
  - load the step counter with WIDTH;
  - go to RUN.
- RUN (busy=1), one step per edge:
  - minuend = {partial_rem[WIDTH-2:0], next dividend MSB};
  - subtract in WIDTH+1 bits, {1'b0,minuend} - {1'b0,divisor};
  - no borrow: partial_rem=difference and quotient bit=1;
  - borrow: partial_rem=minuend and quotient bit=0;
  - shift the quotient bit into the quotient shift register LSB, decrement the counter.
  - On the step where the counter reaches 0, write quotient/remainder outputs and go to DONE.
- DONE: done=1, busy=0, one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation with no idle gap.
- start in RUN is ignored. The operand registers are not disturbed, and the request is not queued.
- quotient/remainder/div_zero hold their values until the next DONE. They do not change on accept.
- Counter width: $clog2(WIDTH+1) bits.

## Timing
- Reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, and all internal registers 0.
- Reset is asynchronous. Asserting it mid-RUN aborts immediately, and no done pulse is issued for the aborted operation.
- Accept at edge N. Steps occur at edges N+1..N+WIDTH. Results update and done=1 in the cycle after edge N+WIDTH.
- busy goes high after edge N and low after edge N+WIDTH.
- Throughput: one division per WIDTH+1 cycles with back-to-back starts.
- Outputs are registered only; there is no combinational path from start to busy/done.

## Configuration
- Macro: HWAG_DIV_ZERO_CHECK_EN.
- Defined: on accept with divisor==0, the block skips RUN. It goes IDLE→DONE directly, so done appears in the cycle after edge N. Outputs are quotient={WIDTH{1'b1}}, remainder=dividend, div_zero=1. div_zero is cleared on every nonzero-divisor result.
- Not defined: no detection, and a zero divisor runs the full WIDTH steps. The natural restoring result is the same values (all-ones quotient, remainder=dividend), and div_zero is constant 0.

## Structure
- Shared package hwag_math_pkg:
  - state typedef (IDLE/RUN/DONE);
  - a function returning the counter width for a given WIDTH.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Internal WIDTH+1-bit subtract.
- The sequencer holds the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=8, 100/7 accepted at edge N → done in the cycle after edge N+8, quotient=14, remainder=2, busy high for exactly 8 cycles.
- WIDTH=8, 255/1 then 5/9 back-to-back (second start asserted during DONE) → 255 r0, then 0 r5. The second done arrives 9 cycles after the first.
- WIDTH=16, 0xFFFF/0x00FF → quotient 0x0101, remainder 0. During RUN, a start with 10/3 is ignored: a single done and unchanged operands.
- Divisor 0 with dividend 0x5A, WIDTH=8 → quotient 0xFF, remainder 0x5A.
  - Macro defined: div_zero=1, done one cycle after accept.
  - Macro undefined: div_zero=0, done after 8 steps.
- rst asserted at step 4 of 200/3 → busy/done/quotient/remainder read 0 immediately, with no done pulse. A new 200/3 after release yields 66 r2.
